// File: rtl/pool_window_buffer.sv
// pool_window_buffer
// Collects non-overlapping 2x2 windows (stride 2) from a raster-order pixel
// stream using a single line buffer, and presents each window as one packed
// word {top-left, top-right, bottom-left, bottom-right} to the max-pool stage.
//
// Handshake: a beat happens on a side only in a cycle where valid && ready are
// both high at the rising clock edge; a producer holds valid and data stable
// until that beat. in_ready is combinational (!win_valid || win_ready), so a
// full output register can be drained and refilled in the same cycle.
module pool_window_buffer #(
    parameter int INTEGER_BITS     = 9,
    parameter int FIXED_POINT_BITS = 4,
    parameter int IMG_WIDTH        = 28,
    parameter int IMG_HEIGHT       = 28
) (
    input  logic                                          clk,
    input  logic                                          rst_n,
    input  logic                                          in_valid,
    input  logic [INTEGER_BITS+FIXED_POINT_BITS-1:0]      in_data,
    output logic                                          in_ready,
    output logic                                          win_valid,
    output logic [4*(INTEGER_BITS+FIXED_POINT_BITS)-1:0]  win_data,
    input  logic                                          win_ready,
    output logic                                          frame_done
);

    localparam int W  = INTEGER_BITS + FIXED_POINT_BITS;
    localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [W-1:0]  linebuf [IMG_WIDTH];
    logic [W-1:0]  hold;

    logic in_beat;
    logic out_beat;
    logic last_col;
    logic last_row;
    logic form_win;

    assign in_ready = !win_valid || win_ready;
    assign in_beat  = in_valid && in_ready;
    assign out_beat = win_valid && win_ready;
    assign last_col = (col == CW'(IMG_WIDTH - 1));
    assign last_row = (row == RW'(IMG_HEIGHT - 1));
    // A bottom-right pixel only ever lands on an odd row and odd column; the
    // dangling last column/row of an odd-sized image is always even-indexed,
    // so it is accepted and simply never completes a window.
    assign form_win = in_beat && row[0] && col[0];

    // Raster position of the next pixel to be accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col <= '0;
            row <= '0;
        end else if (in_beat) begin
            if (last_col) begin
                col <= '0;
                row <= last_row ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Top row of each window pair; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (in_beat && !row[0]) begin
            linebuf[col] <= in_data;
        end
    end

    // Bottom-left pixel waits here until its bottom-right partner arrives.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold <= '0;
        end else if (in_beat && row[0] && !col[0]) begin
            hold <= in_data;
        end
    end

    // Output register: a freshly formed window wins over a drain in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win_valid <= 1'b0;
            win_data  <= '0;
        end else if (form_win) begin
            win_valid <= 1'b1;
            win_data  <= {linebuf[col - CW'(1)], linebuf[col], hold, in_data};
        end else if (out_beat) begin
            win_valid <= 1'b0;
        end
    end

    // One-cycle pulse after the final pixel of a frame is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_done <= 1'b0;
        end else begin
            frame_done <= in_beat && last_col && last_row;
        end
    end

endmodule

// File: tb/tb_pool_window_buffer.sv
// Bench for pool_window_buffer: three instances (4x4, 5x3, 2x2) share clock,
// reset and win_ready; sel routes the input stream to one of them and picks
// which outputs are observed. Inputs change at posedge+1, outputs are
// sampled on the falling edge.
module tb_pool_window_buffer;

  localparam int W  = 13;
  localparam int WW = 4 * W;

  logic clk;
  logic rst_n;
  logic in_valid;
  logic [W-1:0] in_data;
  logic win_ready;
  logic [1:0] sel;
  logic in_is_br;
  logic in_is_last;

  logic ir_a, wv_a, fd_a, ir_b, wv_b, fd_b, ir_c, wv_c, fd_c;
  logic [WW-1:0] wd_a, wd_b, wd_c;

  logic in_ready_m, win_valid_m, frame_done_m;
  logic [WW-1:0] win_data_m;

  logic [WW-1:0] exp_q[$];
  int n_checks;
  int n_fail;
  int n_win;
  int n_fd;
  logic prev_br;
  logic prev_last;

  pool_window_buffer #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(4), .IMG_HEIGHT(4)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd0)), .in_data(in_data),
    .in_ready(ir_a), .win_valid(wv_a), .win_data(wd_a), .win_ready(win_ready), .frame_done(fd_a));

  pool_window_buffer #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(5), .IMG_HEIGHT(3)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd1)), .in_data(in_data),
    .in_ready(ir_b), .win_valid(wv_b), .win_data(wd_b), .win_ready(win_ready), .frame_done(fd_b));

  pool_window_buffer #(.INTEGER_BITS(9), .FIXED_POINT_BITS(4), .IMG_WIDTH(2), .IMG_HEIGHT(2)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid && (sel == 2'd2)), .in_data(in_data),
    .in_ready(ir_c), .win_valid(wv_c), .win_data(wd_c), .win_ready(win_ready), .frame_done(fd_c));

  always_comb begin
    in_ready_m   = ir_a;
    win_valid_m  = wv_a;
    win_data_m   = wd_a;
    frame_done_m = fd_a;
    case (sel)
      2'd1: begin
        in_ready_m = ir_b; win_valid_m = wv_b; win_data_m = wd_b; frame_done_m = fd_b;
      end
      2'd2: begin
        in_ready_m = ir_c; win_valid_m = wv_c; win_data_m = wd_c; frame_done_m = fd_c;
      end
      default: ;
    endcase
  end

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic push_win(input logic [W-1:0] tl, input logic [W-1:0] tr,
                          input logic [W-1:0] bl, input logic [W-1:0] br);
    exp_q.push_back({tl, tr, bl, br});
  endtask

  // ---------------- scoreboard / monitor ----------------
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_br   = 1'b0;
      prev_last = 1'b0;
    end else begin
      if (prev_br) check("win_latency", 64'(win_valid_m), 64'd1);
      if (frame_done_m || prev_last) check("frame_done", 64'(frame_done_m), 64'(prev_last));
      if (frame_done_m) n_fd++;
      if (win_valid_m && win_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_win", 64'(win_valid_m), 64'd0);
        end else begin
          check("win_data", 64'(win_data_m), 64'(exp_q.pop_front()));
          n_win++;
        end
      end
      prev_br   = in_valid && in_ready_m && in_is_br;
      prev_last = in_valid && in_ready_m && in_is_last;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_px(input logic [W-1:0] d, input logic br, input logic last);
    int waited;
    logic done;
    in_valid   = 1'b1;
    in_data    = d;
    in_is_br   = br;
    in_is_last = last;
    waited     = 0;
    done       = 1'b0;
    while (!done) begin
      @(negedge clk);
      if (in_ready_m) begin
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 50) begin
          check("in_ready_timeout", 64'(in_ready_m), 64'd1);
          done = 1'b1;
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input int w, input int h, input int base);
    for (int r = 0; r < h; r++) begin
      for (int c = 0; c < w; c++) begin
        send_px(W'(base + r * w + c), (r % 2 == 1) && (c % 2 == 1), (r == h - 1) && (c == w - 1));
      end
    end
  endtask

  task automatic end_stream();
    in_valid   = 1'b0;
    in_is_br   = 1'b0;
    in_is_last = 1'b0;
  endtask

  task automatic drain(input string tag, input int exp_wins, input int exp_fd);
    int waited;
    waited = 0;
    while ((exp_q.size() != 0 || win_valid_m) && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_left"}, 64'(exp_q.size()), 64'd0);
    check({tag, "_wins"}, 64'(n_win), 64'(exp_wins));
    check({tag, "_fd"}, 64'(n_fd), 64'(exp_fd));
    exp_q.delete();
    n_win = 0;
    n_fd  = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    end_stream();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic push_4x4(input int base);
    push_win(W'(base + 0),  W'(base + 1),  W'(base + 4),  W'(base + 5));
    push_win(W'(base + 2),  W'(base + 3),  W'(base + 6),  W'(base + 7));
    push_win(W'(base + 8),  W'(base + 9),  W'(base + 12), W'(base + 13));
    push_win(W'(base + 10), W'(base + 11), W'(base + 14), W'(base + 15));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_checks   = 0;
    n_fail     = 0;
    n_win      = 0;
    n_fd       = 0;
    sel        = 2'd0;
    win_ready  = 1'b1;
    in_data    = '0;
    in_valid   = 1'b0;
    in_is_br   = 1'b0;
    in_is_last = 1'b0;
    rst_n      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      check("rst_win_valid", 64'(win_valid_m), 64'd0);
      check("rst_win_data", 64'(win_data_m), 64'd0);
      check("rst_frame_done", 64'(frame_done_m), 64'd0);
      check("rst_in_ready", 64'(in_ready_m), 64'd1);
    end
    sel = 2'd0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 4x4 raster 0..15, always ready
    push_4x4(0);
    send_frame(4, 4, 0);
    end_stream();
    drain("basic", 4, 1);

    // 4x4 with the first window held for 5 cycles
    win_ready = 1'b0;
    push_4x4(0);
    fork
      begin
        send_frame(4, 4, 0);
        end_stream();
      end
      begin
        int i;
        i = 0;
        @(negedge clk);
        while (!win_valid_m && i < 100) begin
          @(negedge clk);
          i++;
        end
        for (int k = 0; k < 5; k++) begin
          check("stall_data", 64'(win_data_m), 64'({13'd0, 13'd1, 13'd4, 13'd5}));
          check("stall_in_ready", 64'(in_ready_m), 64'd0);
          @(negedge clk);
        end
        @(posedge clk);
        #1;
        win_ready = 1'b1;
      end
    join
    drain("stall", 4, 1);

    // 5x3 frame: odd width and height
    sel = 2'd1;
    push_win(13'd0, 13'd1, 13'd5, 13'd6);
    push_win(13'd2, 13'd3, 13'd7, 13'd8);
    send_frame(5, 3, 0);
    end_stream();
    drain("odd", 2, 1);

    // 2x2 frame of negative / extreme words, moved bit-exact
    sel = 2'd2;
    push_win(13'h1FFF, 13'h1000, 13'h0001, 13'h1FF0);
    send_px(13'h1FFF, 1'b0, 1'b0);
    send_px(13'h1000, 1'b0, 1'b0);
    send_px(13'h0001, 1'b0, 1'b0);
    send_px(13'h1FF0, 1'b1, 1'b1);
    end_stream();
    drain("neg", 1, 1);

    // reset mid-frame after 6 pixels, then a clean frame
    sel = 2'd0;
    for (int p = 0; p < 6; p++) send_px(W'(100 + p), 1'b0, 1'b0);
    do_reset();
    check("midrst_win_valid", 64'(win_valid_m), 64'd0);
    check("midrst_in_ready", 64'(in_ready_m), 64'd1);
    push_4x4(0);
    send_frame(4, 4, 0);
    end_stream();
    drain("midrst", 4, 1);

    // two back-to-back frames, no gap in in_valid
    push_4x4(0);
    push_4x4(16);
    send_frame(4, 4, 0);
    send_frame(4, 4, 16);
    end_stream();
    drain("b2b", 8, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
